// File: rtl/joy_shift_reader.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// joy_shift_reader
//
// Reads a chain of PLAYERS parallel-in/serial-out controller shift registers
// over one serial line. Each frame strobes JOY_LOAD low and then clocks out
// PLAYERS*BITS bits with JOY_CLK. The bits collect in a shadow register, and
// that register is copied to the joystick output in a single COMMIT cycle.
//
// Optional feature (macro JOY_DEBOUNCE_EN): two-frame debounce. A joystick
// bit changes only when the current frame and the previous frame agree on
// its value.
//
// Parameters:
//   PLAYERS    controllers on the chain (1..4)
//   BITS       buttons per controller (4..16)
//   DIV        clk cycles per serial half-period (2..255)
//   ACTIVE_LOW 1: the line is inverted before storage (pressed reads as 1)
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   enable       lets a new frame start (looked at only in IDLE)
//   JOY_LOAD     parallel-load strobe to the shift register, active low
//   JOY_CLK      serial shift clock to the shift register
//   JOY_DATA     serial data from the shift register
//   joystick     committed button state, player p at [p*BITS +: BITS]
//   frame_done   one-cycle pulse in the first cycle that shows new joystick
//   busy         high from LOAD entry through COMMIT
//   o_dbg_state  current FSM state (debug)
//
// Handshake: there is no backpressure. frame_done is a pure strobe.
// joystick is valid at all times and changes only in the cycle where
// frame_done is high.
// ---------------------------------------------------------------------------
module joy_shift_reader #(
    parameter int PLAYERS    = 2,
    parameter int BITS       = 12,
    parameter int DIV        = 16,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    output logic                    JOY_LOAD,
    output logic                    JOY_CLK,
    input  logic                    JOY_DATA,
    output logic [PLAYERS*BITS-1:0] joystick,
    output logic                    frame_done,
    output logic                    busy,
    output logic [2:0]              o_dbg_state
);

    localparam int   NBITS = PLAYERS * BITS;
    localparam int   KW    = $clog2(NBITS);
    localparam logic INV   = (ACTIVE_LOW != 0);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_SHIFT_LO = 3'd2,
        S_SHIFT_HI = 3'd3,
        S_COMMIT   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_cnt;
    logic              w_tick;
    logic              w_last;
    logic              w_bit;
    logic [KW-1:0]     r_k;
    logic [NBITS-1:0]  r_shadow;
    logic [NBITS-1:0]  r_joystick;
    logic              r_frame_done;

    assign w_tick = (r_cnt == 8'(DIV - 1));
    assign w_last = (r_k == KW'(NBITS - 1));
    assign w_bit  = JOY_DATA ^ INV;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and strobe decode
    always_comb begin
        w_next   = r_state;
        JOY_LOAD = 1'b1;
        JOY_CLK  = 1'b0;
        busy     = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (enable) w_next = S_LOAD;
            end
            S_LOAD: begin
                JOY_LOAD = 1'b0;
                if (w_tick) w_next = S_SHIFT_LO;
            end
            S_SHIFT_LO: begin
                if (w_tick) w_next = S_SHIFT_HI;
            end
            S_SHIFT_HI: begin
                JOY_CLK = 1'b1;
                if (w_tick) w_next = w_last ? S_COMMIT : S_SHIFT_LO;
            end
            S_COMMIT: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
                busy   = 1'b0;
            end
        endcase
    end

    // Every timed state leaves on its tick. Clearing on the tick is therefore
    // the same as clearing on entry. IDLE and COMMIT hold the counter at zero,
    // so LOAD always starts from a clean count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= 8'd0;
        end else if (r_state == S_IDLE || r_state == S_COMMIT || w_tick) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

`ifdef JOY_DEBOUNCE_EN
    logic [NBITS-1:0] r_prev;
    logic [NBITS-1:0] w_agree;
    assign w_agree = ~(r_shadow ^ r_prev);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_k          <= '0;
            r_shadow     <= '0;
            r_joystick   <= '0;
            r_frame_done <= 1'b0;
`ifdef JOY_DEBOUNCE_EN
            r_prev       <= '0;
`endif
        end else begin
            r_frame_done <= (r_state == S_COMMIT);
            if (r_state == S_LOAD) begin
                r_k <= '0;
            end else if (r_state == S_SHIFT_HI && w_tick && !w_last) begin
                r_k <= r_k + 1'b1;
            end
            // Sample at the end of the low phase, just before the rising
            // JOY_CLK edge that shifts the next bit out.
            if (r_state == S_SHIFT_LO && w_tick) begin
                r_shadow[r_k] <= w_bit;
            end
            if (r_state == S_COMMIT) begin
`ifdef JOY_DEBOUNCE_EN
                r_joystick <= (r_joystick & ~w_agree) | (r_shadow & w_agree);
                r_prev     <= r_shadow;
`else
                r_joystick <= r_shadow;
`endif
            end
        end
    end

    assign joystick    = r_joystick;
    assign frame_done  = r_frame_done;
    assign o_dbg_state = r_state;

endmodule
